// File: rtl/input_fifo.sv
// Input buffer for one router port: a circular FIFO feeding the crossbar, plus a
// packet FSM that requests routing for each header and tracks remaining payload flits.
module input_fifo #(
  parameter int TAM_FLIT   = 16,
  parameter int TAM_BUFFER = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                i_rx,
  input  logic [TAM_FLIT-1:0] i_data_in,
  output logic                o_credit,
  output logic                o_h,
  input  logic                i_ack_h,
  output logic                o_data_av,
  output logic [TAM_FLIT-1:0] o_data,
  input  logic                i_data_ack,
  output logic                o_sender
);

  localparam int PTR_W = (TAM_BUFFER > 1) ? $clog2(TAM_BUFFER) : 1;
  localparam int unsigned DEPTH_I = TAM_BUFFER;
  localparam logic [PTR_W:0] DEPTH = DEPTH_I[PTR_W:0];

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HEADER  = 2'd1,
    S_SIZE    = 2'd2,
    S_PAYLOAD = 2'd3
  } state_t;

  logic [TAM_FLIT-1:0] mem [TAM_BUFFER];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W:0]      count;
  logic [PTR_W:0]      count_next;
  logic [TAM_FLIT-1:0] remaining;
  logic [TAM_FLIT-1:0] remaining_next;
  logic                ack_lat;
  logic                ack_lat_next;
  state_t              state;
  state_t              state_next;

  logic                empty;
  logic                wr_en;
  logic                pop;
  logic                data_av;
  logic [TAM_FLIT-1:0] head;

  assign empty    = (count == '0);
  assign o_credit = (count < DEPTH);
  assign wr_en    = i_rx & o_credit;
  assign head     = mem[rd_ptr];
  assign o_data   = empty ? '0 : head;

  // The head flit is offered only once the routing request has been granted.
  assign data_av   = !empty && (((state == S_HEADER) && ack_lat) ||
                                (state == S_SIZE) || (state == S_PAYLOAD));
  assign o_data_av = data_av;
  assign pop       = data_av & i_data_ack;

  // Occupancy bookkeeping for write/pop combinations.
  always_comb begin
    count_next = count;
    case ({wr_en, pop})
      2'b10:   count_next = count + (PTR_W+1)'(1);
      2'b01:   count_next = count - (PTR_W+1)'(1);
      default: count_next = count;
    endcase
  end

  // FIFO storage and pointers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < TAM_BUFFER; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= i_data_in;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count_next;
    end
  end

  // Packet FSM: next state, grant latch, payload counter and handshake outputs.
  always_comb begin
    state_next     = state;
    ack_lat_next   = ack_lat;
    remaining_next = remaining;
    o_h            = 1'b0;
    o_sender       = 1'b0;
    case (state)
      S_IDLE: begin
        ack_lat_next = 1'b0;
        if (!empty) begin
          state_next = S_HEADER;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_HEADER: begin
        if (ack_lat) begin
          o_sender = 1'b1;
          if (pop) begin
            ack_lat_next = 1'b0;
            state_next   = S_SIZE;
          end else begin
            state_next = S_HEADER;
          end
        end else begin
          o_h          = 1'b1;
          ack_lat_next = i_ack_h;
        end
      end
      S_SIZE: begin
        o_sender = 1'b1;
        if (pop) begin
          remaining_next = head;
          if (head == '0) begin
            state_next = S_IDLE;
          end else begin
            state_next = S_PAYLOAD;
          end
        end else begin
          state_next = S_SIZE;
        end
      end
      S_PAYLOAD: begin
        o_sender = 1'b1;
        if (pop) begin
          // Counter saturates at zero; reaching 1 on a pop closes the packet.
          if (remaining != '0) begin
            remaining_next = remaining - TAM_FLIT'(1);
          end else begin
            remaining_next = remaining;
          end
          if (remaining == TAM_FLIT'(1)) begin
            state_next = S_IDLE;
          end else begin
            state_next = S_PAYLOAD;
          end
        end else begin
          state_next = S_PAYLOAD;
        end
      end
      default: begin
        state_next     = S_IDLE;
        ack_lat_next   = 1'b0;
        remaining_next = '0;
      end
    endcase
  end

  // FSM state registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      ack_lat   <= 1'b0;
      remaining <= '0;
    end else begin
      state     <= state_next;
      ack_lat   <= ack_lat_next;
      remaining <= remaining_next;
    end
  end

endmodule

// File: tb/tb_input_fifo.sv
// Scoreboard bench for input_fifo: accepted flits are queued as expected output
// and compared at every pop; handshake outputs are checked at packet milestones.
module tb_input_fifo;

  localparam int W = 16;
  localparam int D = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic         i_rx;
  logic [W-1:0] i_data_in;
  logic         o_credit;
  logic         o_h;
  logic         i_ack_h;
  logic         o_data_av;
  logic [W-1:0] o_data;
  logic         i_data_ack;
  logic         o_sender;

  int           n_checks = 0;
  int           n_errors = 0;
  logic [W-1:0] exp_q[$];
  int           mdl_cnt = 0;
  logic         last_pop;

  input_fifo #(.TAM_FLIT(W), .TAM_BUFFER(D)) dut (
    .clock      (clock),
    .reset      (reset),
    .i_rx       (i_rx),
    .i_data_in  (i_data_in),
    .o_credit   (o_credit),
    .o_h        (o_h),
    .i_ack_h    (i_ack_h),
    .o_data_av  (o_data_av),
    .o_data     (o_data),
    .i_data_ack (i_data_ack),
    .o_sender   (o_sender)
  );

  always #5 clock = ~clock;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive, sample at the falling edge, update the model, step past the rising edge.
  task automatic cycle(input logic rx, input logic [W-1:0] din, input logic ackh, input logic dack);
    logic wr;
    logic [W-1:0] e;
    i_rx = rx; i_data_in = din; i_ack_h = ackh; i_data_ack = dack;
    @(negedge clock);
    last_pop = o_data_av && dack;
    check_value("credit", {31'd0, o_credit}, {31'd0, (mdl_cnt < D)});
    if (last_pop) begin
      if (exp_q.size() == 0) begin
        check_value("pop_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_value("pop_data", {16'd0, o_data}, {16'd0, e});
      end
    end
    wr = rx && (mdl_cnt < D);
    if (wr) exp_q.push_back(din);
    mdl_cnt = mdl_cnt + (wr ? 1 : 0) - (last_pop ? 1 : 0);
    @(posedge clock);
    #1;
    i_rx = 1'b0; i_ack_h = 1'b0; i_data_ack = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    i_rx = 1'b0; i_data_in = '0; i_ack_h = 1'b0; i_data_ack = 1'b0;
    exp_q.delete();
    mdl_cnt = 0;
    #1;
    check_value("rst_credit", {31'd0, o_credit}, 32'd1);
    check_value("rst_h", {31'd0, o_h}, 32'd0);
    check_value("rst_av", {31'd0, o_data_av}, 32'd0);
    check_value("rst_sender", {31'd0, o_sender}, 32'd0);
    check_value("rst_data", {16'd0, o_data}, 32'd0);
    repeat (3) @(posedge clock);
    #1;
    check_value("rst_hold_credit", {31'd0, o_credit}, 32'd1);
    reset = 1'b1;
  endtask

  task automatic wait_h(input logic [W-1:0] hdr);
    for (int i = 0; i < 10 && !o_h; i++) cycle(1'b0, '0, 1'b0, 1'b0);
    check_value("h_seen", {31'd0, o_h}, 32'd1);
    check_value("h_no_av", {31'd0, o_data_av}, 32'd0);
    check_value("h_data", {16'd0, o_data}, {16'd0, hdr});
    cycle(1'b0, '0, 1'b1, 1'b0);
    check_value("ack_h_low", {31'd0, o_h}, 32'd0);
    check_value("ack_sender", {31'd0, o_sender}, 32'd1);
  endtask

  task automatic drain(input int n);
    int got = 0;
    for (int i = 0; i < 20 && got < n; i++) begin
      cycle(1'b0, '0, 1'b0, 1'b1);
      if (last_pop) got++;
    end
    check_value("drain_count", got, n);
  endtask

  task automatic wr(input logic [W-1:0] d);
    cycle(1'b1, d, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset values
    do_reset();

    // Basic packet: header, size 2, two payload flits
    wr(16'h0011); wr(16'h0002); wr(16'hAAAA); wr(16'hBBBB);
    wait_h(16'h0011);
    drain(4);
    check_value("b_sender_fall", {31'd0, o_sender}, 32'd0);
    check_value("b_av_empty", {31'd0, o_data_av}, 32'd0);

    // Overflow: fifth write is dropped
    wr(16'h0050); wr(16'h0002); wr(16'h00C1); wr(16'h00C2);
    check_value("c_full_credit", {31'd0, o_credit}, 32'd0);
    wr(16'hDEAD);
    wait_h(16'h0050);
    drain(4);
    cycle(1'b0, '0, 1'b0, 1'b1);
    check_value("c_no_fifth", {31'd0, o_data_av}, 32'd0);
    check_value("c_sender", {31'd0, o_sender}, 32'd0);

    // Zero-size packet followed by a one-flit packet
    wr(16'h0022); wr(16'h0000); wr(16'h0033); wr(16'h0001);
    wait_h(16'h0022);
    drain(2);
    check_value("d_sender_fall", {31'd0, o_sender}, 32'd0);
    check_value("d_h_idle", {31'd0, o_h}, 32'd0);
    wr(16'h1234);
    wait_h(16'h0033);
    drain(3);
    check_value("d_sender_end", {31'd0, o_sender}, 32'd0);

    // Reset in the middle of a packet, then a clean packet
    wr(16'h0060); wr(16'h0005); wr(16'h0E01); wr(16'h0E02);
    wait_h(16'h0060);
    drain(4);
    wr(16'h0E03);
    check_value("e_mid_sender", {31'd0, o_sender}, 32'd1);
    do_reset();
    wr(16'h0044); wr(16'h0001); wr(16'h5555);
    wait_h(16'h0044);
    drain(3);
    check_value("e_sender_end", {31'd0, o_sender}, 32'd0);

    // Stray grant in idle is ignored; simultaneous write and pop at occupancy 3
    cycle(1'b0, '0, 1'b1, 1'b0);
    wr(16'h0070); wr(16'h0003); wr(16'h00A1);
    wait_h(16'h0070);
    cycle(1'b1, 16'h00A2, 1'b0, 1'b1);
    check_value("f_credit_1", {31'd0, o_credit}, 32'd1);
    cycle(1'b1, 16'h00A3, 1'b0, 1'b1);
    check_value("f_credit_2", {31'd0, o_credit}, 32'd1);
    drain(3);
    check_value("f_sender_end", {31'd0, o_sender}, 32'd0);
    check_value("f_av_empty", {31'd0, o_data_av}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule

// File: doc/input_fifo.md
INPUT_FIFO -- requirements
Module: input_fifo

Interface
REQ-001 SHALL have parameter TAM_FLIT, default 16, flit width in bits.
REQ-002 SHALL have parameter TAM_BUFFER, default 4, FIFO depth in flits (power of 2, >=2).
REQ-003 SHALL have port clock  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_rx  input  1  upstream flit valid.
REQ-006 SHALL have port i_data_in  input  TAM_FLIT  upstream flit.
REQ-007 SHALL have port o_credit  output  1  FIFO can accept a flit this cycle.
REQ-008 SHALL have port o_h  output  1  header at FIFO head, routing requested.
REQ-009 SHALL have port i_ack_h  input  1  switch control accepted the routing request.
REQ-010 SHALL have port o_data_av  output  1  flit at o_data valid toward crossbar.
REQ-011 SHALL have port o_data  output  TAM_FLIT  FIFO head flit.
REQ-012 SHALL have port i_data_ack  input  1  crossbar consumed the head flit.
REQ-013 SHALL have port o_sender  output  1  packet in transit; switch control frees the connection on its fall.

Function
REQ-014 Packet format SHALL be: flit 0 header, flit 1 size N (unsigned, TAM_FLIT bits), then N payload flits; N=0 is legal.
REQ-015 o_credit SHALL equal (occupancy < TAM_BUFFER), combinational from registered occupancy.
REQ-016 Write SHALL occur on an edge with i_rx=1 and o_credit=1; i_rx while o_credit=0 SHALL be dropped, with no state change.
REQ-017 Pop SHALL occur on an edge with o_data_av=1 and i_data_ack=1; i_data_ack with o_data_av=0 SHALL be ignored.
REQ-018 Simultaneous write and pop SHALL leave occupancy unchanged; when full, o_credit=0 blocks the write even if a pop occurs in that cycle.
REQ-019 Read and write pointers SHALL wrap modulo TAM_BUFFER.
REQ-020 o_data SHALL be the FIFO head combinationally; a flit written at edge k SHALL appear on o_data after edge k if the FIFO was empty.
REQ-021 FSM states SHALL be S_IDLE, S_HEADER, S_SIZE, S_PAYLOAD.
REQ-022 S_IDLE: o_h=0, o_data_av=0, o_sender=0; FIFO non-empty -> S_HEADER on next edge.
REQ-023 S_HEADER: o_h=1, o_data_av=0 until i_ack_h=1; then o_h=0, o_sender=1, o_data_av=(FIFO non-empty); pop of header -> S_SIZE.
REQ-024 The i_ack_h latch SHALL be held internally (o_sender=1) until the header pops; i_ack_h outside S_HEADER SHALL be ignored.
REQ-025 S_SIZE: o_data_av=(FIFO non-empty), o_sender=1; on pop, load the remaining counter with the flit value; N=0 -> S_IDLE, else -> S_PAYLOAD.
REQ-026 S_PAYLOAD: o_data_av=(FIFO non-empty), o_sender=1; each pop decrements the counter; pop with counter=1 -> S_IDLE, o_sender=0 after that edge.
REQ-027 The remaining counter SHALL be TAM_FLIT bits wide, with no wrap (it never decrements below 1 in S_PAYLOAD).
REQ-028 Flits of the next packet SHALL be accepted during the current packet; after return to S_IDLE with FIFO non-empty, S_HEADER SHALL be entered on the following edge.

Reset
REQ-029 While reset=0: FIFO empty, pointers 0, counter 0, state S_IDLE, o_credit=1, o_h=0, o_data_av=0, o_sender=0, o_data=0.
REQ-030 Reset asserted mid-packet SHALL discard all buffered flits and the partial packet; operation after release SHALL start from S_IDLE.

Verification
REQ-031 Reset: assert reset=0 for 3 cycles -> o_credit=1, o_h=0, o_data_av=0, o_sender=0.
REQ-032 Write 0x0011,0x0002,0xAAAA,0xBBBB; i_ack_h one cycle after o_h; i_data_ack=1 -> o_data shows 0x0011,0x0002,0xAAAA,0xBBBB on consecutive pops; o_sender falls after the 0xBBBB pop.
REQ-033 Depth 4, no i_ack_h: write 5 flits -> o_credit=0 after the 4th; the 5th is dropped; after draining, the 5th value never appears.
REQ-034 Packet 0x0022,0x0000 then 0x0033,0x0001,0x1234 -> the first packet ends on the size pop; o_h reasserts for 0x0033.
REQ-035 Size 0x0005, reset=0 after 2 payload pops -> all outputs at reset values; a following packet 0x0044,0x0001,0x5555 is delivered intact.
REQ-036 Occupancy 3 with simultaneous i_rx=1 and pop -> occupancy stays 3, o_credit stays 1, FIFO order preserved.
